// File: rtl/i2c_master_cmd_sequencer.sv
// Write-command sequencer feeding the I2C bus-control FSM: accept -> Start in 1 cycle, ack_evt -> Send in 2 cycles.
// Command side is valid/ready (IDLE only); write bytes are buffered in a small FIFO whose ready drops when full.
module i2c_seq_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         i_push,
   input  logic [W-1:0] i_dat,
   input  logic         i_pop,
   input  logic         i_flush,
   output logic         o_rdy,
   output logic         o_vld,
   output logic [W-1:0] o_dat
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          w_pop;
   logic          w_push;

   assign o_rdy  = (r_count != FULL);
   assign o_vld  = (r_count != '0);
   assign o_dat  = r_mem[r_rptr];
   assign w_pop  = i_pop && o_vld;
   // A pop frees the slot being written, so a push into a full FIFO still lands when paired with a pop.
   assign w_push = i_push && (o_rdy || w_pop);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_push && !i_flush) r_mem[r_wptr] <= i_dat;
   end
endmodule

module i2c_master_cmd_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_W      = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [9:0]       cmd_addr,
   input  logic             cmd_rw,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [7:0]       wr_data,
   output logic [9:0]       SADR,
   output logic             RW_MODE,
   output logic             Start_Condition,
   output logic             Send_Data,
   output logic             Stop_Condition,
   output logic [7:0]       i_transmit_data,
   input  logic             wait_ack,
   input  logic             sda_in,
   output logic             busy,
   output logic             done,
   output logic             nack_err,
   output logic             timeout_err,
   output logic [LEN_W-1:0] bytes_sent
);
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, START, ADDR_WAIT, ACK_CHK, LOAD, DATA_WAIT, STOP, DONE
   } state_t;

   state_t           r_state;
   logic [9:0]       r_addr;
   logic             r_rw;
   logic [LEN_W-1:0] r_rem;
   logic [LEN_W-1:0] r_bytes;
   logic [TW-1:0]    r_timer;
   logic [7:0]       r_txd;
   logic             r_start, r_send, r_stop, r_done;
   logic             r_nack, r_tmo, r_sda, r_wait_q, r_data_ph;
   logic             w_ack_evt, w_fifo_vld, w_issue, w_flush;
   logic [7:0]       w_fifo_dat;
   logic [LEN_W-1:0] w_rem_nx;

   assign w_ack_evt = wait_ack && !r_wait_q;
   assign w_rem_nx  = r_data_ph ? (r_rem - 1'b1) : r_rem;
   assign w_flush   = (r_state == STOP) && (r_nack || r_tmo);
   // ACK_CHK issues the next byte directly when the FIFO already holds it; LOAD only covers the empty case.
   assign w_issue   = w_fifo_vld &&
                      ((r_state == LOAD) ||
                       ((r_state == ACK_CHK) && !r_sda && (w_rem_nx != '0)));

   i2c_seq_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
      .CLK     (CLK),
      .RST     (RST),
      .i_push  (wr_valid),
      .i_dat   (wr_data),
      .i_pop   (w_issue),
      .i_flush (w_flush),
      .o_rdy   (wr_ready),
      .o_vld   (w_fifo_vld),
      .o_dat   (w_fifo_dat)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state   <= IDLE;
         r_addr    <= '0;
         r_rw      <= 1'b0;
         r_rem     <= '0;
         r_bytes   <= '0;
         r_timer   <= '0;
         r_txd     <= '0;
         r_start   <= 1'b0;
         r_send    <= 1'b0;
         r_stop    <= 1'b0;
         r_done    <= 1'b0;
         r_nack    <= 1'b0;
         r_tmo     <= 1'b0;
         r_sda     <= 1'b0;
         r_wait_q  <= 1'b0;
         r_data_ph <= 1'b0;
      end else begin
         r_wait_q <= wait_ack;
         r_start  <= 1'b0;
         r_send   <= 1'b0;
         r_stop   <= 1'b0;
         r_done   <= 1'b0;
         case (r_state)
            IDLE: if (cmd_valid) begin
               r_addr    <= cmd_addr;
               r_rw      <= cmd_rw;
               r_rem     <= cmd_rw ? '0 : cmd_len;
               r_nack    <= 1'b0;
               r_tmo     <= 1'b0;
               r_bytes   <= '0;
               r_data_ph <= 1'b0;
               r_start   <= 1'b1;
               r_state   <= START;
            end
            START: begin
               r_timer <= '0;
               r_state <= ADDR_WAIT;
            end
            ADDR_WAIT, DATA_WAIT: begin
               if (w_ack_evt) begin
                  r_sda   <= sda_in;
                  r_state <= ACK_CHK;
               end else if (r_timer == TMAX) begin
                  r_tmo   <= 1'b1;
                  r_stop  <= 1'b1;
                  r_state <= STOP;
               end else if (r_timer != '1) begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            ACK_CHK: begin
               if (r_sda) begin
                  r_nack  <= 1'b1;
                  r_stop  <= 1'b1;
                  r_state <= STOP;
               end else begin
                  if (r_data_ph) r_bytes <= r_bytes + 1'b1;
                  r_rem <= w_rem_nx;
                  if (w_rem_nx == '0) begin
                     r_stop  <= 1'b1;
                     r_state <= STOP;
                  end else if (w_issue) begin
                     r_txd     <= w_fifo_dat;
                     r_send    <= 1'b1;
                     r_timer   <= '0;
                     r_data_ph <= 1'b1;
                     r_state   <= DATA_WAIT;
                  end else begin
                     r_state <= LOAD;
                  end
               end
            end
            LOAD: if (w_issue) begin
               r_txd     <= w_fifo_dat;
               r_send    <= 1'b1;
               r_timer   <= '0;
               r_data_ph <= 1'b1;
               r_state   <= DATA_WAIT;
            end
            STOP: begin
               r_done  <= 1'b1;
               r_state <= DONE;
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign cmd_ready       = (r_state == IDLE);
   assign busy            = (r_state != IDLE);
   assign SADR            = r_addr;
   assign RW_MODE         = r_rw;
   assign Start_Condition = r_start;
   assign Send_Data       = r_send;
   assign Stop_Condition  = r_stop;
   assign i_transmit_data = r_txd;
   assign done            = r_done;
   assign nack_err        = r_nack;
   assign timeout_err     = r_tmo;
   assign bytes_sent      = r_bytes;
endmodule

// File: tb/tb_i2c_master_cmd_sequencer.sv
// Directed bench for i2c_master_cmd_sequencer: table of whole transactions plus hand-written timing corners.
// The bench plays the bus-control FSM, raising wait_ack for one cycle per ACK window.
module tb_i2c_master_cmd_sequencer;
   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       cmd_valid = 1'b0, cmd_rw = 1'b0, wr_valid = 1'b0, wait_ack = 1'b0, sda_in = 1'b0;
   logic [9:0] cmd_addr = '0;
   logic [3:0] cmd_len = '0;
   logic [7:0] wr_data = '0;
   logic       cmd_ready, wr_ready, RW_MODE, Start_Condition, Send_Data, Stop_Condition;
   logic       busy, done, nack_err, timeout_err;
   logic [9:0] SADR;
   logic [7:0] i_transmit_data;
   logic [3:0] bytes_sent;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   i2c_master_cmd_sequencer #(.FIFO_DEPTH(4), .LEN_W(4), .TIMEOUT(64)) dut (
      .CLK(CLK), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_rw(cmd_rw),
      .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .SADR(SADR), .RW_MODE(RW_MODE), .Start_Condition(Start_Condition), .Send_Data(Send_Data),
      .Stop_Condition(Stop_Condition), .i_transmit_data(i_transmit_data), .wait_ack(wait_ack),
      .sda_in(sda_in), .busy(busy), .done(done), .nack_err(nack_err), .timeout_err(timeout_err),
      .bytes_sent(bytes_sent)
   );

   typedef struct packed {
      logic [9:0]      addr;
      logic            rw;
      logic [3:0]      len;
      logic [1:0]      npush;
      logic [2:0][7:0] push_dat;
      logic [3:0]      nack_win;   // 15 = every window ACKed
      logic [2:0][7:0] exp_tx;
      logic [3:0]      exp_bytes;
      logic            exp_nack;
      logic [2:0]      exp_cnt;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      tick();
      wr_valid = 1'b0;
   endtask

   // Returns in the cycle right after the accepting edge (the Start pulse cycle).
   task automatic issue_cmd(input logic [9:0] a, input logic rw, input logic [3:0] len);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_rw    = rw;
      cmd_len   = len;
      tick();
      cmd_valid = 1'b0;
   endtask

   // One-cycle ACK window; returns two cycles after the window (where Send or Stop must show).
   task automatic ack_win(input logic nack);
      wait_ack = 1'b1;
      sda_in   = nack;
      tick();
      wait_ack = 1'b0;
      sda_in   = 1'b0;
      tick();
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      chk({tag, "_wr_ready"}, wr_ready, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pulses"}, {Start_Condition, Send_Data, Stop_Condition}, 0);
      chk({tag, "_errs"}, {nack_err, timeout_err}, 0);
      chk({tag, "_bytes"}, bytes_sent, 0);
      chk({tag, "_sadr_rw"}, {SADR, RW_MODE}, 0);
      chk({tag, "_txd"}, i_transmit_data, 0);
      chk({tag, "_fifo_cnt"}, dut.u_fifo.r_count, 0);
   endtask

   function automatic vec_t mk(input logic [9:0] a, input logic rw, input logic [3:0] len,
                               input logic [1:0] np, input logic [23:0] pd, input logic [3:0] nw,
                               input logic [23:0] tx, input logic [3:0] eb, input logic en,
                               input logic [2:0] ec);
      vec_t v;
      v.addr = a; v.rw = rw; v.len = len; v.npush = np; v.push_dat = pd; v.nack_win = nw;
      v.exp_tx = tx; v.exp_bytes = eb; v.exp_nack = en; v.exp_cnt = ec;
      return v;
   endfunction

   always @(negedge CLK) begin
      if (RST) chk("pulse_excl", 32'($countones({Start_Condition, Send_Data, Stop_Condition}) > 1), 0);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t v;
      int   nwin;
      int   stop_at;

      vecs[0] = mk(10'h050, 0, 2, 2, {8'h00, 8'h3C, 8'hA5}, 15, {8'h00, 8'h3C, 8'hA5}, 2, 0, 0);
      vecs[1] = mk(10'h021, 0, 0, 1, {8'h00, 8'h00, 8'h77}, 15, 24'h0,                  0, 0, 1);
      vecs[2] = mk(10'h02A, 0, 3, 2, {8'h00, 8'h22, 8'h11}, 2,  {8'h00, 8'h11, 8'h77}, 1, 1, 0);
      vecs[3] = mk(10'h3FF, 1, 3, 1, {8'h00, 8'h00, 8'hAA}, 15, 24'h0,                  0, 0, 1);
      vecs[4] = mk(10'h055, 0, 1, 0, 24'h0,                  0,  24'h0,                  0, 1, 0);

      repeat (3) tick();
      check_reset("rst");
      RST = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) begin
         v = vecs[i];
         for (int p = 0; p < int'(v.npush); p++) push(v.push_dat[p]);
         issue_cmd(v.addr, v.rw, v.len);
         chk("start_pulse", Start_Condition, 1);
         chk("sadr", SADR, v.addr);
         chk("rw_mode", RW_MODE, v.rw);
         chk("cmd_ready_busy", {cmd_ready, busy}, 2'b01);
         tick();
         nwin = v.rw ? 1 : int'(v.len) + 1;
         for (int w = 0; w < nwin; w++) begin
            tick();
            tick();
            ack_win(w == int'(v.nack_win));
            if (w == int'(v.nack_win) || w == nwin - 1) begin
               chk("stop_pulse", {Stop_Condition, Send_Data}, 2'b10);
               break;
            end
            chk("send_pulse", {Send_Data, Stop_Condition}, 2'b10);
            chk("send_byte", i_transmit_data, v.exp_tx[w]);
         end
         tick();
         chk("done_pulse", done, 1);
         chk("bytes_sent", bytes_sent, v.exp_bytes);
         chk("nack_err", nack_err, v.exp_nack);
         chk("timeout_err", timeout_err, 0);
         tick();
         chk("back_idle", {cmd_ready, busy, done}, 3'b100);
         chk("fifo_cnt_after", dut.u_fifo.r_count, v.exp_cnt);
      end

      // FIFO empty at the first data slot: sequencer must wait without timing out.
      issue_cmd(10'h010, 0, 2);
      chk("t4_start", Start_Condition, 1);
      tick();
      ack_win(0);
      chk("t4_no_send_empty", {Send_Data, Stop_Condition}, 0);
      repeat (80) tick();
      chk("t4_wait_no_tmo", {timeout_err, busy, Send_Data}, 3'b010);
      push(8'h5A);
      chk("t4_send_not_yet", Send_Data, 0);
      tick();
      chk("t4_send_after_push", Send_Data, 1);
      chk("t4_send_byte", i_transmit_data, 8'h5A);
      push(8'h6B);
      ack_win(0);
      chk("t4_send2", Send_Data, 1);
      chk("t4_send2_byte", i_transmit_data, 8'h6B);
      ack_win(0);
      chk("t4_stop", Stop_Condition, 1);
      tick();
      chk("t4_done", {done, timeout_err, nack_err}, 3'b100);
      chk("t4_bytes", bytes_sent, 2);
      tick();

      // wait_ack never rises: Stop appears 65 cycles after the Start pulse cycle.
      issue_cmd(10'h033, 0, 0);
      chk("t5_start", Start_Condition, 1);
      stop_at = 0;
      for (int k = 1; k <= 100; k++) begin
         tick();
         if (Stop_Condition) begin
            stop_at = k;
            break;
         end
      end
      chk("t5_stop_cycle", stop_at, 65);
      chk("t5_timeout_err", timeout_err, 1);
      tick();
      chk("t5_done", {done, timeout_err}, 2'b11);
      tick();

      // An ACK in the very last allowed cycle is still accepted.
      issue_cmd(10'h034, 0, 0);
      repeat (64) tick();
      chk("t5b_no_tmo_yet", {Stop_Condition, timeout_err}, 0);
      ack_win(0);
      chk("t5b_stop", {Stop_Condition, timeout_err}, 2'b10);
      tick();
      chk("t5b_done", {done, timeout_err}, 2'b10);
      tick();

      // Full FIFO, dropped push, push+pop while full, then reset mid-transaction.
      push(8'hC1);
      push(8'hC2);
      push(8'hC3);
      push(8'hC4);
      chk("t6_full_ready", wr_ready, 0);
      chk("t6_full_cnt", dut.u_fifo.r_count, 4);
      push(8'hC5);
      chk("t6_drop_cnt", dut.u_fifo.r_count, 4);
      issue_cmd(10'h044, 0, 2);
      tick();
      wait_ack = 1'b1;
      tick();
      wait_ack = 1'b0;
      wr_valid = 1'b1;
      wr_data  = 8'hD0;
      tick();
      wr_valid = 1'b0;
      chk("t6_send", Send_Data, 1);
      chk("t6_send_byte", i_transmit_data, 8'hC1);
      chk("t6_pushpop_cnt", dut.u_fifo.r_count, 4);
      chk("t6_pushpop_ready", wr_ready, 0);
      RST = 1'b0;
      #1;
      check_reset("midrst");
      tick();
      check_reset("midrst_next");
      RST = 1'b1;
      tick();
      chk("post_rst_idle", {cmd_ready, busy, Stop_Condition}, 3'b100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
